// File: rtl/ip_rx_if.sv
// Port bundle for ip_rx: IPv4 byte stream in, header channel and payload stream out.
// The slave view is the ip_rx side; the master view drives it (MAC side plus downstream readies).
interface ip_rx_if #(parameter int AXI_DATA_WIDTH = 8);
  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata;
  logic                      s_axis_tvalid;
  logic                      s_axis_tlast;
  logic                      s_axis_trdy;

  logic [AXI_DATA_WIDTH-1:0] m_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tlast;
  logic                      m_axis_trdy;

  logic                      m_ip_hdr_tvalid;
  logic                      m_ip_hdr_trdy;
  logic [31:0]               m_ip_src_addr;
  logic [31:0]               m_ip_dst_addr;
  logic [7:0]                m_ip_protocol;
  logic [15:0]               m_ip_payload_len;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_trdy, m_ip_hdr_trdy,
    output s_axis_trdy, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
           m_ip_hdr_tvalid, m_ip_src_addr, m_ip_dst_addr, m_ip_protocol, m_ip_payload_len
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_trdy, m_ip_hdr_trdy,
    input  s_axis_trdy, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
           m_ip_hdr_tvalid, m_ip_src_addr, m_ip_dst_addr, m_ip_protocol, m_ip_payload_len
  );
endinterface

// File: rtl/ip_rx.sv
// IPv4 receive de-encapsulation: parses/validates a 20-byte header, emits header fields,
// forwards the payload through a single output register, and drops malformed packets.
module ip_rx #(
  parameter int AXI_DATA_WIDTH = 8
) (
  input  logic    i_clk,
  input  logic    i_reset,
  ip_rx_if.slave  bus,
  output logic    o_hdr_err
);

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_HDR_OUT = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [4:0]                r_idx;
  logic [19:0]               r_acc;
  logic [7:0]                r_hi;
  logic                      r_ver_ok;
  logic [15:0]               r_tot_len;
  logic [13:0]               r_frag;
  logic [7:0]                r_proto;
  logic [31:0]               r_src;
  logic [31:0]               r_dst;
  logic [15:0]               r_pay_len;
  logic [15:0]               r_cnt;
  logic                      r_m_tvalid;
  logic                      r_m_tlast;
  logic [AXI_DATA_WIDTH-1:0] r_m_tdata;
  logic                      r_hdr_err;

  logic [19:0] w_acc_sum;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;
  logic        w_hdr_good;
  logic        w_s_trdy;
  logic        w_err;
  logic        w_hdr_accept;
  logic        w_pay_accept;

  // Each odd byte closes a big-endian word; byte 1 starts a fresh sum so no clear is needed.
  assign w_acc_sum = (r_idx == 5'd1 ? 20'd0 : r_acc) + {4'd0, r_hi, bus.s_axis_tdata};
  assign w_fold1   = {1'b0, w_acc_sum[15:0]} + {13'd0, w_acc_sum[19:16]};
  assign w_fold2   = w_fold1[15:0] + {15'd0, w_fold1[16]};

  // Evaluated only while byte 19 is on the bus; every other field is already captured.
  assign w_hdr_good = (w_fold2 == 16'hFFFF) && r_ver_ok && (r_tot_len >= 16'd21) &&
                      !r_frag[13] && (r_frag[12:0] == 13'd0);

  assign w_hdr_accept = (r_state == S_HDR) && bus.s_axis_tvalid;
  assign w_pay_accept = (r_state == S_PAYLOAD) && bus.s_axis_tvalid && w_s_trdy;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_HDR;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_trdy    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_HDR: begin
        w_s_trdy = 1'b1;
        if (bus.s_axis_tvalid) begin
          if (r_idx == 5'd19) begin
            if (w_hdr_good) begin
              w_state_nxt = S_HDR_OUT;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = bus.s_axis_tlast ? S_HDR : S_DRAIN;
            end
          end else if (bus.s_axis_tlast) begin
            w_err = 1'b1;
          end
        end
      end
      S_HDR_OUT: begin
        if (bus.m_ip_hdr_trdy) w_state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        w_s_trdy = !r_m_tvalid || bus.m_axis_trdy;
        if (bus.s_axis_tvalid && w_s_trdy) begin
          if (r_cnt == 16'd1) begin
            w_state_nxt = bus.s_axis_tlast ? S_HDR : S_DRAIN;
          end else if (bus.s_axis_tlast) begin
            w_err       = 1'b1;
            w_state_nxt = S_HDR;
          end
        end
      end
      S_DRAIN: begin
        w_s_trdy = 1'b1;
        if (bus.s_axis_tvalid && bus.s_axis_tlast) w_state_nxt = S_HDR;
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  // Header capture and checksum accumulation
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_idx     <= 5'd0;
      r_acc     <= 20'd0;
      r_hi      <= 8'd0;
      r_ver_ok  <= 1'b0;
      r_tot_len <= 16'd0;
      r_frag    <= 14'd0;
      r_proto   <= 8'd0;
      r_src     <= 32'd0;
      r_dst     <= 32'd0;
      r_pay_len <= 16'd0;
    end else if (w_hdr_accept) begin
      r_idx <= (bus.s_axis_tlast || r_idx == 5'd19) ? 5'd0 : r_idx + 5'd1;
      if (!r_idx[0]) r_hi  <= bus.s_axis_tdata;
      else           r_acc <= w_acc_sum;
      case (r_idx)
        5'd0:  r_ver_ok        <= (bus.s_axis_tdata == 8'h45);
        5'd2:  r_tot_len[15:8] <= bus.s_axis_tdata;
        5'd3:  r_tot_len[7:0]  <= bus.s_axis_tdata;
        5'd6:  r_frag[13:8]    <= bus.s_axis_tdata[5:0];
        5'd7:  r_frag[7:0]     <= bus.s_axis_tdata;
        5'd9:  r_proto         <= bus.s_axis_tdata;
        5'd12, 5'd13, 5'd14, 5'd15: r_src <= {r_src[23:0], bus.s_axis_tdata};
        5'd16, 5'd17, 5'd18, 5'd19: r_dst <= {r_dst[23:0], bus.s_axis_tdata};
        default: ;
      endcase
      if (r_idx == 5'd19) r_pay_len <= r_tot_len - 16'd20;
    end
  end

  // Payload counter and output register; the register drains independently of the FSM
  // so a held last byte never blocks parsing of the next header.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt      <= 16'd0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
      r_hdr_err  <= 1'b0;
    end else begin
      r_hdr_err <= w_err;
      if (r_state == S_HDR_OUT && bus.m_ip_hdr_trdy) r_cnt <= r_pay_len;
      if (w_pay_accept) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= bus.s_axis_tdata;
        r_m_tlast  <= (r_cnt == 16'd1) || bus.s_axis_tlast;
        r_cnt      <= r_cnt - 16'd1;
      end else if (bus.m_axis_trdy) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign bus.s_axis_trdy      = w_s_trdy && !i_reset;
  assign bus.m_axis_tvalid    = r_m_tvalid;
  assign bus.m_axis_tdata     = r_m_tdata;
  assign bus.m_axis_tlast     = r_m_tlast;
  assign bus.m_ip_hdr_tvalid  = (r_state == S_HDR_OUT);
  assign bus.m_ip_src_addr    = r_src;
  assign bus.m_ip_dst_addr    = r_dst;
  assign bus.m_ip_protocol    = r_proto;
  assign bus.m_ip_payload_len = r_pay_len;
  assign o_hdr_err            = r_hdr_err;

endmodule

// File: tb/tb_ip_rx.sv
// Self-checking bench for ip_rx: directed vector table, mid-header reset, and 100 random
// back-to-back packets scored against a packet-level reference model.
module tb_ip_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hdr_err;

  ip_rx_if #(.AXI_DATA_WIDTH(8)) bus();

  ip_rx #(.AXI_DATA_WIDTH(8)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .bus       (bus),
    .o_hdr_err (hdr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [7:0]  proto;
    logic [15:0] len;
  } hdr_t;

  typedef struct {
    string       name;
    logic [7:0]  b0;
    logic [15:0] tot;
    logic [15:0] frag;
    int          csum_delta;
    int          n_total;
    int          exp_hdr_n;
    int          exp_pay_n;
    int          exp_err_n;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pkt[$];
  hdr_t       exp_hdr[$], got_hdr[$];
  logic [8:0] exp_pay[$], got_pay[$];
  int         got_cyc[$];
  int         exp_err = 0, got_err = 0;
  int         cyc = 0;
  bit         rand_rdy = 1'b0;
  int         hdr_delay = 0;
  int         hw_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [8:0] prev_word = '0;
  vec_t       vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream readies: payload ready random or steady, header ready after hdr_delay cycles.
  initial begin
    bus.m_axis_trdy   = 1'b1;
    bus.m_ip_hdr_trdy = 1'b0;
    forever begin
      @(negedge clk);
      bus.m_axis_trdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.m_ip_hdr_tvalid) begin
        bus.m_ip_hdr_trdy = (hw_cnt >= hdr_delay);
        hw_cnt++;
      end else begin
        hw_cnt = 0;
        bus.m_ip_hdr_trdy = 1'b0;
      end
    end
  end

  // Monitor: inputs settle at negedge, handshakes are sampled 1 ns later.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          chk("payload hold", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata},
              {1'b1, prev_word});
        if (bus.m_axis_tvalid && bus.m_axis_trdy) begin
          got_pay.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
          got_cyc.push_back(cyc);
        end
        if (bus.m_ip_hdr_tvalid && bus.m_ip_hdr_trdy)
          got_hdr.push_back({bus.m_ip_src_addr, bus.m_ip_dst_addr, bus.m_ip_protocol,
                             bus.m_ip_payload_len});
        if (hdr_err) got_err++;
        prev_stall = bus.m_axis_tvalid && !bus.m_axis_trdy;
        prev_word  = {bus.m_axis_tlast, bus.m_axis_tdata};
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic build(input logic [7:0] b0, input logic [15:0] tot, input logic [15:0] frag,
                       input logic [31:0] src, input logic [31:0] dst, input logic [7:0] proto,
                       input int csum_delta, input int n_total, input bit rnd_pay);
    logic [31:0] s;
    logic [15:0] c;
    pkt.delete();
    pkt.push_back(b0);         pkt.push_back(8'h00);
    pkt.push_back(tot[15:8]);  pkt.push_back(tot[7:0]);
    pkt.push_back(8'h1C);      pkt.push_back(8'h46);
    pkt.push_back(frag[15:8]); pkt.push_back(frag[7:0]);
    pkt.push_back(8'h40);      pkt.push_back(proto);
    pkt.push_back(8'h00);      pkt.push_back(8'h00);
    for (int i = 3; i >= 0; i--) pkt.push_back(src[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) pkt.push_back(dst[i*8 +: 8]);
    s = 32'd0;
    for (int w = 0; w < 10; w++) s = s + {16'd0, pkt[2*w], pkt[2*w+1]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    c = ~s[15:0];
    c = c + 16'(csum_delta);
    pkt[10] = c[15:8];
    pkt[11] = c[7:0];
    for (int i = 0; pkt.size() < n_total; i++) pkt.push_back(rnd_pay ? 8'($urandom) : 8'(i));
    while (pkt.size() > n_total) void'(pkt.pop_back());
  endtask

  // Reference model: what a correct receiver emits for the packet currently in pkt.
  task automatic model_pkt();
    int n, plen, avail, cnt;
    logic [31:0] s;
    logic [15:0] tot;
    bit good;
    n = pkt.size();
    if (n < 20) begin
      exp_err++;
      return;
    end
    s = 32'd0;
    for (int w = 0; w < 10; w++) s = s + {16'd0, pkt[2*w], pkt[2*w+1]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    tot  = {pkt[2], pkt[3]};
    good = (pkt[0] == 8'h45) && (s[15:0] == 16'hFFFF) && (tot >= 16'd21) &&
           (pkt[6][5] == 1'b0) && ({pkt[6][4:0], pkt[7]} == 13'd0);
    if (!good) begin
      exp_err++;
      return;
    end
    exp_hdr.push_back({pkt[12], pkt[13], pkt[14], pkt[15], pkt[16], pkt[17], pkt[18], pkt[19],
                       pkt[9], tot - 16'd20});
    plen  = int'(tot) - 20;
    avail = n - 20;
    cnt   = (plen < avail) ? plen : avail;
    for (int i = 0; i < cnt; i++) exp_pay.push_back({i == cnt - 1, pkt[20 + i]});
    if (avail < plen) exp_err++;
  endtask

  // Leaves tvalid high after the last byte so consecutive calls run back-to-back.
  task automatic send_n(input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = pkt[i];
      bus.s_axis_tlast  = (i == pkt.size() - 1);
      #1;
      guard = 0;
      while (!bus.s_axis_trdy) begin
        @(negedge clk);
        #1;
        guard++;
        if (guard > 500) begin
          chk("s_axis_trdy timeout", 64'd0, 64'd1);
          bus.s_axis_tvalid = 1'b0;
          return;
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((got_pay.size() < exp_pay.size() || got_hdr.size() < exp_hdr.size()) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic check_results(input string tag, input int hdr_n, input int pay_n, input int err_n);
    chk({tag, " hdr count"}, 64'(got_hdr.size()), 64'(hdr_n));
    chk({tag, " payload count"}, 64'(got_pay.size()), 64'(pay_n));
    chk({tag, " err pulses"}, 64'(got_err), 64'(err_n));
    for (int i = 0; i < got_hdr.size() && i < exp_hdr.size(); i++) begin
      chk({tag, " src"},   64'(got_hdr[i].src),   64'(exp_hdr[i].src));
      chk({tag, " dst"},   64'(got_hdr[i].dst),   64'(exp_hdr[i].dst));
      chk({tag, " proto"}, 64'(got_hdr[i].proto), 64'(exp_hdr[i].proto));
      chk({tag, " len"},   64'(got_hdr[i].len),   64'(exp_hdr[i].len));
    end
    for (int i = 0; i < got_pay.size() && i < exp_pay.size(); i++)
      chk({tag, " payload byte"}, 64'(got_pay[i]), 64'(exp_pay[i]));
    got_hdr.delete(); exp_hdr.delete();
    got_pay.delete(); exp_pay.delete(); got_cyc.delete();
    got_err = 0; exp_err = 0;
  endtask

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = 8'd0;
    bus.s_axis_tlast  = 1'b0;

    vecs[0]  = '{"good",         8'h45, 16'd36,  16'h0000, 0, 36,  1, 16,  0};
    vecs[1]  = '{"padded",       8'h45, 16'd36,  16'h0000, 0, 46,  1, 16,  0};
    vecs[2]  = '{"after pad",    8'h45, 16'd36,  16'h0000, 0, 36,  1, 16,  0};
    vecs[3]  = '{"csum+1",       8'h45, 16'd36,  16'h0000, 1, 36,  0, 0,   1};
    vecs[4]  = '{"after csum",   8'h45, 16'd36,  16'h0000, 0, 36,  1, 16,  0};
    vecs[5]  = '{"ver 46",       8'h46, 16'd36,  16'h0000, 0, 36,  0, 0,   1};
    vecs[6]  = '{"mf",           8'h45, 16'd36,  16'h2000, 0, 36,  0, 0,   1};
    vecs[7]  = '{"frag off",     8'h45, 16'd36,  16'h0001, 0, 36,  0, 0,   1};
    vecs[8]  = '{"df ok",        8'h45, 16'd36,  16'h4000, 0, 36,  1, 16,  0};
    vecs[9]  = '{"totlen 20",    8'h45, 16'd20,  16'h0000, 0, 22,  0, 0,   1};
    vecs[10] = '{"totlen 21",    8'h45, 16'd21,  16'h0000, 0, 21,  1, 1,   0};
    vecs[11] = '{"trunc pay",    8'h45, 16'd36,  16'h0000, 0, 28,  1, 8,   1};
    vecs[12] = '{"trunc hdr",    8'h45, 16'd36,  16'h0000, 0, 11,  0, 0,   1};
    vecs[13] = '{"bad csum b19", 8'h45, 16'd36,  16'h0000, 1, 20,  0, 0,   1};

    repeat (3) @(negedge clk);
    #1;
    chk("reset m_axis_tvalid",   64'(bus.m_axis_tvalid),    64'd0);
    chk("reset m_ip_hdr_tvalid", 64'(bus.m_ip_hdr_tvalid),  64'd0);
    chk("reset o_hdr_err",       64'(hdr_err),              64'd0);
    chk("reset payload_len",     64'(bus.m_ip_payload_len), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("s_axis_trdy after reset", 64'(bus.s_axis_trdy), 64'd1);

    for (int v = 0; v < 14; v++) begin
      build(vecs[v].b0, vecs[v].tot, vecs[v].frag, 32'hC0A8010A, 32'hC0A80114, 8'h11,
            vecs[v].csum_delta, vecs[v].n_total, 1'b0);
      model_pkt();
      send_n(pkt.size());
      idle();
      wait_drain();
      if (v == 0)
        chk("throughput 16 bytes", 64'((got_cyc.size() == 16) ? got_cyc[15] - got_cyc[0] : -1),
            64'd15);
      check_results(vecs[v].name, vecs[v].exp_hdr_n, vecs[v].exp_pay_n, vecs[v].exp_err_n);
    end

    // Reset in the middle of a header, then a clean packet.
    build(8'h45, 16'd36, 16'h0000, 32'h0A000001, 32'h0A000002, 8'h06, 0, 36, 1'b1);
    send_n(10);
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst m_axis_tvalid",   64'(bus.m_axis_tvalid),   64'd0);
    chk("midrst m_ip_hdr_tvalid", 64'(bus.m_ip_hdr_tvalid), 64'd0);
    chk("midrst src cleared",     64'(bus.m_ip_src_addr),   64'd0);
    chk("midrst dst cleared",     64'(bus.m_ip_dst_addr),   64'd0);
    chk("midrst o_hdr_err",       64'(hdr_err),             64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst s_axis_trdy", 64'(bus.s_axis_trdy), 64'd1);
    got_hdr.delete(); got_pay.delete(); got_cyc.delete(); got_err = 0;
    model_pkt();
    send_n(pkt.size());
    idle();
    wait_drain();
    check_results("after reset", 1, 16, 0);

    // Random back-to-back traffic with payload backpressure and a slow header consumer.
    rand_rdy  = 1'b1;
    hdr_delay = 5;
    for (int p = 0; p < 100; p++) begin
      int kind, plen, ntot, delta;
      logic [7:0]  b0;
      logic [15:0] frag;
      kind  = $urandom_range(0, 99);
      plen  = $urandom_range(1, 30);
      ntot  = plen + 20;
      delta = 0;
      b0    = 8'h45;
      frag  = ($urandom_range(0, 1) == 1) ? 16'h4000 : 16'h0000;
      if (kind < 10)      delta = $urandom_range(1, 255);
      else if (kind < 15) b0 = ($urandom_range(0, 1) == 1) ? 8'h46 : 8'h44;
      else if (kind < 20) frag = 16'h2000;
      else if (kind < 30) ntot = 20 + $urandom_range(1, plen);
      else if (kind < 40) ntot = ntot + $urandom_range(1, 20);
      build(b0, 16'(plen + 20), frag, $urandom, $urandom, 8'($urandom), delta, ntot, 1'b1);
      model_pkt();
      send_n(pkt.size());
    end
    idle();
    wait_drain();
    check_results("random", exp_hdr.size(), exp_pay.size(), exp_err);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ip_rx.md
# ip_rx

Receive-side IPv4 de-encapsulation stage. It sits directly upstream of `udp_rx`. It accepts an IPv4 packet as a byte-wide AXI-Stream from the MAC receive path, then parses and validates the 20-byte IPv4 header. It presents the header fields on a separate valid/ready header channel and forwards the IP payload (the UDP datagram) on a master AXI-Stream that feeds `udp_rx` directly. Malformed packets are consumed and discarded without emitting a header or payload.

## Interface
- `AXI_DATA_WIDTH`, default 8: stream data width. Only 8 is supported.
- `i_clk` input 1: system clock; all logic is on the rising edge.
- `i_reset` input 1: asynchronous, active-high reset.
- `s_axis_tdata` input 8: IPv4 packet byte, most significant byte first.
- `s_axis_tvalid` input 1: input byte valid.
- `s_axis_tlast` input 1: last byte of the frame, including any Ethernet padding.
- `s_axis_trdy` output 1: input ready.
- `m_axis_tdata` output 8: payload byte.
- `m_axis_tvalid` output 1: payload byte valid.
- `m_axis_tlast` output 1: last payload byte.
- `m_axis_trdy` input 1: downstream ready.
- `m_ip_hdr_tvalid` output 1: header fields valid.
- `m_ip_hdr_trdy` input 1: header accepted.
- `m_ip_src_addr` output 32: source address.
- `m_ip_dst_addr` output 32: destination address.
- `m_ip_protocol` output 8: protocol field.
- `m_ip_payload_len` output 16: total_length − 20.
- `o_hdr_err` output 1: one-cycle pulse when a packet is dropped or truncated.

## Operation
States:
- **HDR**: accept bytes 0–19, capturing fields. `s_axis_trdy`=1.
  - A 20-bit checksum accumulator adds each big-endian 16-bit word.
  - Byte 0 must be 0x45, i.e. version 4 and IHL 5; options are unsupported.
  - At byte 19, fold the accumulator twice (`acc[15:0] + acc[19:16]`). The header is good when:
    - the folded result is 0xFFFF,
    - byte 0 is 0x45,
    - total_length ≥ 21,
    - bytes 6–7 have MF=0 and fragment offset=0.
  - Good header → **HDR_OUT**. Otherwise pulse `o_hdr_err` and go to **DRAIN**, or to **HDR** if byte 19 carries tlast.
  - tlast on any header byte before 19 → pulse `o_hdr_err`, go to **HDR** (next packet).
- **HDR_OUT**: `m_ip_hdr_tvalid`=1, `s_axis_trdy`=0. Fields stay stable until `m_ip_hdr_trdy`; on that handshake → **PAYLOAD** and load the byte counter with payload_len.
- **PAYLOAD**: single-register output stage.
  - `s_axis_trdy` = `!m_axis_tvalid || m_axis_trdy`.
  - Each accepted byte is registered to `m_axis_tdata` and decrements the counter.
  - `m_axis_tlast`=1 on the byte where the counter reaches 1.
  - If that byte also has `s_axis_tlast` → **HDR**; otherwise → **DRAIN**.
  - Input tlast before the counter reaches 1: register the byte with `m_axis_tlast`=1, pulse `o_hdr_err`, go to **HDR**.
- **DRAIN**: `s_axis_trdy`=1, discard bytes (padding or bad packet) until `s_axis_tlast` → **HDR**.
- The next packet header may be accepted while the last payload byte is still held in the output register. Header parsing does not depend on `m_axis_trdy`.

## Timing
- Reset values: state **HDR**; all outputs 0, except `s_axis_trdy`=1 once out of reset.
- Header fields register as their bytes are accepted. `m_ip_hdr_tvalid` rises the cycle after byte 19 is accepted.
- Payload latency is 1 cycle from input acceptance to `m_axis_tvalid`.
- `m_axis_tdata`/`m_axis_tlast` must hold while `m_axis_tvalid && !m_axis_trdy`.
- Full throughput: with `m_axis_trdy` held at 1, one byte per cycle.
- `o_hdr_err` is asserted for exactly one cycle per offending packet.
- Reset asserted mid-packet clears everything immediately. The first byte accepted after release is treated as header byte 0.

## Test plan
- Good packet: src C0A8010A, dst C0A80114, protocol 0x11, total_length 36, correct checksum, 16-byte payload 0x00..0x0F, all readies high. Expect:
  - header fields exact, payload_len 16;
  - 16 payload bytes in order, tlast on 0x0F;
  - `o_hdr_err` never asserted.
- Same packet padded to 46 bytes with tlast on byte 45. Expect 16 payload bytes out, padding dropped, and the next packet parsed correctly.
- Checksum word corrupted by +1. Expect no `m_ip_hdr_tvalid`, no payload, one `o_hdr_err` pulse, and the following good packet received intact.
- Byte 0 = 0x46, then separately MF=1. Expect each packet dropped with an `o_hdr_err` pulse.
- Random `m_axis_trdy` (50%) and `m_ip_hdr_trdy` delayed 5 cycles, over 100 back-to-back random packets. Expect payload identical to the golden model with no loss or duplication.
- total_length 36 but input tlast on payload byte 7. Expect 8 bytes out with tlast on the 8th and one `o_hdr_err` pulse. Then `i_reset` pulsed mid-header: outputs clear, and the next packet is correct.
